// File: rtl/fb_source_switch_ctrl.sv
// Frame-safe source select for the framebuffer input mux; latches per-frame config.
// Optional frame counter enabled by defining FB_FRAME_CNT_EN.
module fb_source_switch_ctrl #(
  parameter logic [23:0] TIMEOUT_CYC  = 24'd4000000,
  parameter logic [7:0]  PARALLAX_RST = 8'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_frame,
  input  logic [3:0]  hps_switch,
  input  logic [7:0]  parallax_corr,
  input  logic        err_clr,
  input  logic [3:0]  sop_src,
  input  logic [3:0]  eop_src,
  input  logic [3:0]  valid_src,
  output logic [1:0]  sel,
  output logic        fb_gate,
  output logic        switch_busy,
  output logic [7:0]  reg_parallax_corr,
  output logic        enable_tone_mapping,
  output logic        timeout_err,
  output logic [15:0] frame_cnt
);
  typedef enum logic [1:0] {STREAM, WAIT_EOP, WAIT_SOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d, tgt_q, tgt_d, req;
  logic        gate_q, gate_d, busy_q, busy_d, tm_q, tm_d, err_q, err_d;
  logic [7:0]  par_q, par_d;
  logic [23:0] timer_q, timer_d;
  logic        eop_sel, sop_tgt, timeout;
  logic        unused_hps3;

  assign unused_hps3 = hps_switch[3];

  always_comb begin
    case (hps_switch[1:0])
      2'b10:   req = 2'd1;
      2'b11:   req = hps_switch[2] ? 2'd3 : 2'd2;
      default: req = 2'd0;
    endcase
  end

  assign eop_sel = eop_src[sel_q] & valid_src[sel_q];
  assign sop_tgt = sop_src[tgt_q] & valid_src[tgt_q];
  assign timeout = (timer_q == TIMEOUT_CYC - 24'd1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    gate_d  = gate_q;
    par_d   = par_q;
    tm_d    = tm_q;
    err_d   = err_q;
    timer_d = timer_q;
    if (start_frame) begin
      par_d = parallax_corr;
      tm_d  = hps_switch[2];
    end
    if (err_clr) err_d = 1'b0;
    case (state_q)
      STREAM: begin
        if (req != sel_q) begin
          state_d = WAIT_EOP;
          timer_d = 24'd0;
        end
      end
      WAIT_EOP: begin
        timer_d = timer_q + 24'd1;
        if (timeout) begin
          sel_d   = req;
          gate_d  = 1'b1;
          err_d   = 1'b1;
          state_d = STREAM;
        end else if (eop_sel) begin
          // eop beat still passes; blanking starts the cycle after
          tgt_d   = req;
          gate_d  = 1'b0;
          state_d = WAIT_SOP;
        end else if (req == sel_q) begin
          state_d = STREAM;
        end
      end
      WAIT_SOP: begin
        timer_d = timer_q + 24'd1;
        if (timeout) begin
          sel_d   = tgt_q;
          gate_d  = 1'b1;
          err_d   = 1'b1;
          state_d = STREAM;
        end else if (sop_tgt) begin
          sel_d   = tgt_q;
          gate_d  = 1'b1;
          state_d = STREAM;
        end
      end
      default: state_d = STREAM;
    endcase
    busy_d = (state_d != STREAM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STREAM;
      sel_q   <= 2'd0;
      tgt_q   <= 2'd0;
      gate_q  <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= PARALLAX_RST;
      tm_q    <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= 24'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
      tm_q    <= tm_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

`ifdef FB_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  always_comb begin
    fcnt_d = fcnt_q;
    if (eop_sel && gate_q) fcnt_d = fcnt_q + 16'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt_q <= 16'd0;
    else       fcnt_q <= fcnt_d;
  end
  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign sel                 = sel_q;
  assign fb_gate             = gate_q;
  assign switch_busy         = busy_q;
  assign reg_parallax_corr   = par_q;
  assign enable_tone_mapping = tm_q;
  assign timeout_err         = err_q;
endmodule

// File: tb/tb_fb_source_switch_ctrl.sv
// Directed bench for fb_source_switch_ctrl (TIMEOUT_CYC=16); frame counter checks follow FB_FRAME_CNT_EN.
module tb_fb_source_switch_ctrl;
  logic        clk = 1'b0;
  logic        reset, start_frame, err_clr;
  logic [3:0]  hps_switch, sop_src, eop_src, valid_src;
  logic [7:0]  parallax_corr;
  logic [1:0]  sel;
  logic        fb_gate, switch_busy, enable_tone_mapping, timeout_err;
  logic [7:0]  reg_parallax_corr;
  logic [15:0] frame_cnt;
  int errors = 0;
  int checks = 0;

  fb_source_switch_ctrl #(.TIMEOUT_CYC(24'd16), .PARALLAX_RST(8'd10)) dut (
    .clk(clk), .reset(reset), .start_frame(start_frame), .hps_switch(hps_switch),
    .parallax_corr(parallax_corr), .err_clr(err_clr), .sop_src(sop_src),
    .eop_src(eop_src), .valid_src(valid_src), .sel(sel), .fb_gate(fb_gate),
    .switch_busy(switch_busy), .reg_parallax_corr(reg_parallax_corr),
    .enable_tone_mapping(enable_tone_mapping), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [3:0] sop, input logic [3:0] eop, input logic [3:0] vld);
    sop_src = sop; eop_src = eop; valid_src = vld;
    tick();
    sop_src = 4'b0; eop_src = 4'b0; valid_src = 4'b0;
  endtask

  initial begin
    reset = 1'b1; start_frame = 1'b0; err_clr = 1'b0; hps_switch = 4'b0001;
    sop_src = 4'b0; eop_src = 4'b0; valid_src = 4'b0; parallax_corr = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    // reset state
    chk("rst_sel", 16'(sel), 16'd0);
    chk("rst_gate", 16'(fb_gate), 16'd1);
    chk("rst_par", 16'(reg_parallax_corr), 16'd10);
    chk("rst_busy", 16'(switch_busy), 16'd0);
    chk("rst_tm", 16'(enable_tone_mapping), 16'd0);
    chk("rst_err", 16'(timeout_err), 16'd0);
    chk("rst_fcnt", frame_cnt, 16'd0);

    // three gated cam0 frames
    repeat (3) beat(4'b0000, 4'b0001, 4'b0001);
`ifdef FB_FRAME_CNT_EN
    chk("fcnt_3", frame_cnt, 16'd3);
`else
    chk("fcnt_tied", frame_cnt, 16'd0);
`endif

    // cam0 -> cam1 switch
    hps_switch = 4'b0010;
    tick();
    chk("sw_busy", 16'(switch_busy), 16'd1);
    chk("sw_gate_hold", 16'(fb_gate), 16'd1);
    beat(4'b0000, 4'b0001, 4'b0000);           // eop without valid ignored
    chk("sw_novld_gate", 16'(fb_gate), 16'd1);
    beat(4'b0000, 4'b0001, 4'b0001);           // eop cam0
    chk("sw_eop_gate", 16'(fb_gate), 16'd0);
    chk("sw_eop_sel", 16'(sel), 16'd0);
    tick();
    chk("sw_blank", 16'(fb_gate), 16'd0);
    beat(4'b0010, 4'b0000, 4'b0010);           // sop cam1
    chk("sw_sop_sel", 16'(sel), 16'd1);
    chk("sw_sop_gate", 16'(fb_gate), 16'd1);
    chk("sw_done_busy", 16'(switch_busy), 16'd0);

    // tone-mapped source and config latching
    hps_switch = 4'b0111; parallax_corr = 8'h20;
    tick();
    chk("par_nolatch", 16'(reg_parallax_corr), 16'd10);
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0; parallax_corr = 8'h55;
    chk("par_latch", 16'(reg_parallax_corr), 16'h20);
    chk("tm_latch", 16'(enable_tone_mapping), 16'd1);
    tick();
    chk("par_hold", 16'(reg_parallax_corr), 16'h20);
    beat(4'b0000, 4'b0010, 4'b0010);           // eop cam1
    chk("tm_eop_gate", 16'(fb_gate), 16'd0);
    beat(4'b1000, 4'b0000, 4'b1000);           // sop tm
    chk("tm_sel", 16'(sel), 16'd3);
    chk("tm_gate", 16'(fb_gate), 16'd1);

    // withdrawn request
    hps_switch = 4'b0001;
    tick();
    chk("wd_busy", 16'(switch_busy), 16'd1);
    hps_switch = 4'b0111;
    tick();
    chk("wd_busy_clr", 16'(switch_busy), 16'd0);
    chk("wd_sel", 16'(sel), 16'd3);
    chk("wd_gate", 16'(fb_gate), 16'd1);

    // timeout forces the switch on the 16th cycle
    hps_switch = 4'b0010;
    tick();
    repeat (15) tick();
    chk("to_pre_sel", 16'(sel), 16'd3);
    chk("to_pre_busy", 16'(switch_busy), 16'd1);
    tick();
    chk("to_sel", 16'(sel), 16'd1);
    chk("to_err", 16'(timeout_err), 16'd1);
    chk("to_gate", 16'(fb_gate), 16'd1);
    chk("to_busy", 16'(switch_busy), 16'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", 16'(timeout_err), 16'd0);

    // timeout set beats a same-cycle err_clr
    hps_switch = 4'b0001;
    tick();
    repeat (15) tick();
    err_clr = 1'b1;
    tick();
    chk("to2_setwins", 16'(timeout_err), 16'd1);
    chk("to2_sel", 16'(sel), 16'd0);
    tick();
    err_clr = 1'b0;
    chk("to2_clr", 16'(timeout_err), 16'd0);

    // eop(sel) and sop(tgt) together: only eop acts
    hps_switch = 4'b0010;
    tick();
    beat(4'b0010, 4'b0001, 4'b0011);
    chk("sim_gate", 16'(fb_gate), 16'd0);
    chk("sim_sel", 16'(sel), 16'd0);
    tick();
    chk("sim_blank", 16'(fb_gate), 16'd0);
    beat(4'b0010, 4'b0000, 4'b0010);
    chk("sim_sel1", 16'(sel), 16'd1);
    chk("sim_gate1", 16'(fb_gate), 16'd1);

    // reset mid-switch discards the pending request
    hps_switch = 4'b0001; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_busy", 16'(switch_busy), 16'd0);
    chk("mr_sel", 16'(sel), 16'd0);
    chk("mr_par", 16'(reg_parallax_corr), 16'd10);
    chk("mr_tm", 16'(enable_tone_mapping), 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_after_busy", 16'(switch_busy), 16'd0);

`ifdef FB_FRAME_CNT_EN
    eop_src = 4'b0001; valid_src = 4'b0001;
    repeat (65535) tick();
    chk("fcnt_ffff", frame_cnt, 16'hFFFF);
    tick();
    chk("fcnt_wrap", frame_cnt, 16'h0000);
    eop_src = 4'b0; valid_src = 4'b0;
`else
    beat(4'b0000, 4'b0001, 4'b0001);
    chk("fcnt_tied2", frame_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
